step_sequencer: RTL
===================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 The module SHALL have parameter CNT_WIDTH, default 32, the width of the step count.
REQ-002 The module SHALL have parameter PERIOD_WIDTH, default 24, the width of the step period in clk cycles.
REQ-003 The module SHALL have parameter PULSE_CLKS, default 8, the step high time in clk cycles (>=1).
REQ-004 The module SHALL have parameter DIR_SETUP_CLKS, default 4, the dir-to-step setup time in clk cycles (>=1).
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 aclr_n  input  1  asynchronous active-low reset.
REQ-007 sclr  input  1  synchronous clear, active-high.
REQ-008 cmd_valid  input  1  move command present.
REQ-009 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-010 cmd_dir  input  1  move direction.
REQ-011 cmd_steps  input  CNT_WIDTH  unsigned number of steps.
REQ-012 cmd_period  input  PERIOD_WIDTH  requested step period in clk cycles.
REQ-013 abort  input  1  stop the current move.
REQ-014 step  output  1  step pulse to the phase generator.
REQ-015 dir  output  1  direction to the phase generator.
REQ-016 busy  output  1  move in progress.
REQ-017 done  output  1  one-cycle pulse when a move ends (completed, aborted or zero-length).
REQ-018 steps_left  output  CNT_WIDTH  steps remaining in the current move.

Function
REQ-019 The state machine SHALL have states IDLE, SETUP, HIGH and LOW; busy SHALL be 1 in every state except IDLE.
REQ-020 All outputs SHALL be registered; cmd_ready SHALL be 1 only in IDLE with sclr low and SHALL drop in the cycle after acceptance.
REQ-021 Effective period P SHALL be max(cmd_period, 2*PULSE_CLKS), latched at acceptance; later input changes SHALL have no effect on the current move.
REQ-022 On acceptance with cmd_steps==0, the module SHALL stay in IDLE, emit no step and assert done in the next cycle.
REQ-023 On acceptance with cmd_steps>0 and cmd_dir==dir, the module SHALL enter HIGH and assert step in the next cycle, with steps_left=cmd_steps.
REQ-024 On acceptance with cmd_steps>0 and cmd_dir!=dir, dir SHALL update in the next cycle, the state SHALL be SETUP for DIR_SETUP_CLKS cycles, and HIGH SHALL follow.
REQ-025 step SHALL be high for exactly PULSE_CLKS cycles in HIGH and low for exactly P-PULSE_CLKS cycles in LOW.
REQ-026 steps_left SHALL decrement by 1 on the HIGH->LOW transition.
REQ-027 At the end of LOW, the module SHALL go to HIGH if steps_left>0, otherwise to IDLE with done asserted for one cycle.
REQ-028 dir SHALL change only on acceptance, never in HIGH, LOW or SETUP.
REQ-029 abort in SETUP or LOW SHALL force IDLE in the next cycle with done=1 and steps_left held.
REQ-030 abort in HIGH SHALL let the current pulse finish its full PULSE_CLKS (no runt pulse), decrement steps_left, then go to IDLE with done=1, skipping LOW.
REQ-031 abort in IDLE SHALL be ignored; when abort and cmd_valid occur in the same cycle in IDLE, the command SHALL be accepted.
REQ-032 sclr SHALL take priority over all inputs and drive the reset values of REQ-033 at the next edge.

Reset
REQ-033 While aclr_n is low, step=0, dir=0, busy=0, done=0, steps_left=0, cmd_ready=0 and state=IDLE; cmd_ready SHALL rise on the first clk edge after release.

Verification
REQ-034 Reset: aclr_n low for 10 clocks -> all outputs 0; cmd_ready=1 one cycle after release.
REQ-035 Basic move (dir=0): steps=3, period=20 -> three pulses of 8 high and 12 low; steps_left goes 3,2,1,0; done is asserted 60 cycles after the first step rise.
REQ-036 Direction change: steps=2, dir=1 from dir=0 -> dir rises 1 cycle after acceptance and step rises 4 cycles after dir.
REQ-037 Period clamp: period=5 -> step 8 high, 8 low.
REQ-038 Abort: steps=5, abort in the 3rd cycle of pulse 2 -> pulse 2 stays high for the full 8 cycles; no further pulses; steps_left=3; one done pulse.
REQ-039 Zero length: steps=0 -> step never rises; done one cycle after acceptance; cmd_ready=1 again in the cycle after done.

Source files
------------

// File: rtl/step_sequencer.sv
// Step/direction pulse sequencer: runs one move command as a train of fixed-width
// step pulses at a clamped period, with direction setup time and clean abort.
module step_sequencer #(
  parameter int CNT_WIDTH      = 32,
  parameter int PERIOD_WIDTH   = 24,
  parameter int PULSE_CLKS     = 8,
  parameter int DIR_SETUP_CLKS = 4
) (
  input  logic                    clk,
  input  logic                    aclr_n,
  input  logic                    sclr,
  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on internal state, and cmd_* are sampled only on that edge.
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [CNT_WIDTH-1:0]    cmd_steps,
  input  logic [PERIOD_WIDTH-1:0] cmd_period,
  input  logic                    abort,
  output logic                    step,
  output logic                    dir,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    steps_left,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  localparam logic [PERIOD_WIDTH-1:0] PW    = PERIOD_WIDTH'(PULSE_CLKS);
  localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(2 * PULSE_CLKS);
  localparam logic [PERIOD_WIDTH-1:0] DS    = PERIOD_WIDTH'(DIR_SETUP_CLKS);
  localparam logic [PERIOD_WIDTH-1:0] ONE_P = PERIOD_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]    ONE_C = CNT_WIDTH'(1);

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic [PERIOD_WIDTH-1:0] low_len;
  logic [PERIOD_WIDTH-1:0] eff_period;
  logic                    abort_pend;
  logic                    accept;

  assign accept    = cmd_valid && cmd_ready;
  assign dbg_state = state;

  always_comb begin
    eff_period = (cmd_period < MIN_P) ? MIN_P : cmd_period;
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state      <= IDLE;
      cnt        <= '0;
      low_len    <= '0;
      abort_pend <= 1'b0;
      cmd_ready  <= 1'b0;
      step       <= 1'b0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      steps_left <= '0;
    end else if (sclr) begin
      state      <= IDLE;
      cnt        <= '0;
      low_len    <= '0;
      abort_pend <= 1'b0;
      cmd_ready  <= 1'b0;
      step       <= 1'b0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      steps_left <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready  <= 1'b0;
            steps_left <= cmd_steps;
            low_len    <= eff_period - PW;
            abort_pend <= 1'b0;
            if (cmd_steps == '0) begin
              done <= 1'b1;
            end else if (cmd_dir == dir) begin
              state <= HIGH;
              step  <= 1'b1;
              busy  <= 1'b1;
              cnt   <= PW - ONE_P;
            end else begin
              state <= SETUP;
              dir   <= cmd_dir;
              busy  <= 1'b1;
              cnt   <= DS - ONE_P;
            end
          end
        end
        SETUP: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cnt == '0) begin
            state <= HIGH;
            step  <= 1'b1;
            cnt   <= PW - ONE_P;
          end else begin
            cnt <= cnt - ONE_P;
          end
        end
        HIGH: begin
          // An abort seen during the pulse is remembered so the pulse still runs full width.
          if (cnt == '0) begin
            step       <= 1'b0;
            steps_left <= steps_left - ONE_C;
            if (abort || abort_pend) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= LOW;
              cnt   <= low_len - ONE_P;
            end
          end else begin
            cnt <= cnt - ONE_P;
            if (abort) abort_pend <= 1'b1;
          end
        end
        LOW: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cnt == '0) begin
            if (steps_left != '0) begin
              state <= HIGH;
              step  <= 1'b1;
              cnt   <= PW - ONE_P;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt - ONE_P;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
